// File: rtl/bp_fpga_host_io_arbiter.sv
// bp_fpga_host_io_arbiter
// Shares the FPGA host IO command/response channel among num_req_p requesters.
// Commands are granted round-robin and passed straight through to the host.
// Each accepted command pushes the issuer ID into a small FIFO. The FIFO head
// routes the next in-order host response back to that issuer with no added latency.
//
// state  | meaning
// e_idle | scanning requesters; a grant that handshakes in the same cycle stays here
// e_lock | host stalled a granted command; hold that grant until the host accepts it
module bp_fpga_host_io_arbiter #(
   parameter int num_req_p         = 2,
   parameter int msg_width_p       = 576,
   parameter int max_outstanding_p = 4
) (
   input  logic                                   clk_i,
   input  logic                                   reset_n_i,
   input  logic [num_req_p*msg_width_p-1:0]       req_cmd_i,
   input  logic [num_req_p-1:0]                   req_cmd_v_i,
   output logic [num_req_p-1:0]                   req_cmd_ready_and_o,
   output logic [msg_width_p-1:0]                 req_resp_o,
   output logic [num_req_p-1:0]                   req_resp_v_o,
   input  logic [num_req_p-1:0]                   req_resp_yumi_i,
   output logic [msg_width_p-1:0]                 host_cmd_o,
   output logic                                   host_cmd_v_o,
   input  logic                                   host_cmd_ready_and_i,
   input  logic [msg_width_p-1:0]                 host_resp_i,
   input  logic                                   host_resp_v_i,
   output logic                                   host_resp_yumi_o,
   output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
   output logic                                   error_o
);

   localparam int id_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int ptr_w = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
   localparam int cnt_w = $clog2(max_outstanding_p+1);

   typedef enum logic {e_idle, e_lock} state_e;

   state_e           state_r;
   logic [id_w-1:0]  rr_r;
   logic [id_w-1:0]  lock_id_r;
   logic [id_w-1:0]  scan_id;
   logic             scan_v;
   logic [id_w-1:0]  sel_id;
   logic [id_w-1:0]  head_id;
   logic             cmd_v;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [id_w-1:0]  id_mem [max_outstanding_p];
   logic [ptr_w-1:0] wr_ptr_r;
   logic [ptr_w-1:0] rd_ptr_r;
   logic [cnt_w-1:0] cnt_r;
   logic             error_r;

   function automatic logic [id_w-1:0] next_id(input logic [id_w-1:0] id);
      return (id == id_w'(num_req_p-1)) ? '0 : id + id_w'(1);
   endfunction

   function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] ptr);
      return (ptr == ptr_w'(max_outstanding_p-1)) ? '0 : ptr + ptr_w'(1);
   endfunction

   assign fifo_full  = (cnt_r == cnt_w'(max_outstanding_p));
   assign fifo_empty = (cnt_r == '0);
   assign head_id    = id_mem[rd_ptr_r];

   // Round-robin scan: first valid requester at or after the rr pointer.
   always_comb begin : scan_blk
      int idx;
      idx     = 0;
      scan_v  = 1'b0;
      scan_id = rr_r;
      for (int i = 0; i < num_req_p; i++) begin
         idx = (int'(rr_r) + i) % num_req_p;
         if (!scan_v && req_cmd_v_i[idx]) begin
            scan_v  = 1'b1;
            scan_id = id_w'(idx);
         end
      end
   end

   // Command path: a locked grant never retargets; fresh grants need FIFO room.
   always_comb begin
      sel_id              = (state_r == e_lock) ? lock_id_r : scan_id;
      cmd_v               = reset_n_i & ((state_r == e_lock) | (scan_v & ~fifo_full));
      push                = cmd_v & host_cmd_ready_and_i;
      host_cmd_v_o        = cmd_v;
      host_cmd_o          = req_cmd_i[int'(sel_id)*msg_width_p +: msg_width_p];
      req_cmd_ready_and_o = '0;
      req_cmd_ready_and_o[sel_id] = push;
   end

   // Response path: route to FIFO head; orphan responses are drained and flagged.
   always_comb begin
      req_resp_o       = host_resp_i;
      req_resp_v_o     = '0;
      host_resp_yumi_o = 1'b0;
      pop              = 1'b0;
      if (reset_n_i) begin
         if (!fifo_empty) begin
            req_resp_v_o[head_id] = host_resp_v_i;
            host_resp_yumi_o      = host_resp_v_i & req_resp_yumi_i[head_id];
            pop                   = host_resp_v_i & req_resp_yumi_i[head_id];
         end else begin
            host_resp_yumi_o = host_resp_v_i;
         end
      end
   end

   // Arbitration FSM and round-robin pointer.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r   <= e_idle;
         rr_r      <= '0;
         lock_id_r <= '0;
      end else begin
         case (state_r)
            e_idle: begin
               if (cmd_v) begin
                  if (host_cmd_ready_and_i) begin
                     rr_r <= next_id(scan_id);
                  end else begin
                     lock_id_r <= scan_id;
                     state_r   <= e_lock;
                  end
               end
            end
            e_lock: begin
               if (host_cmd_ready_and_i) begin
                  rr_r    <= next_id(lock_id_r);
                  state_r <= e_idle;
               end
            end
            default: state_r <= e_idle;
         endcase
      end
   end

   // ID FIFO pointers and occupancy; occupancy kept separately so full and empty differ.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         if (push) wr_ptr_r <= next_ptr(wr_ptr_r);
         if (pop)  rd_ptr_r <= next_ptr(rd_ptr_r);
         case ({push, pop})
            2'b10:   cnt_r <= cnt_r + cnt_w'(1);
            2'b01:   cnt_r <= cnt_r - cnt_w'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // ID storage; contents are meaningless outside the occupied window so no reset.
   always_ff @(posedge clk_i) begin
      if (push) id_mem[wr_ptr_r] <= sel_id;
   end

   // Sticky flag for a host response with nothing outstanding.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) error_r <= 1'b0;
      else if (host_resp_v_i && fifo_empty) error_r <= 1'b1;
   end

   assign outstanding_o = cnt_r;
   assign error_o       = error_r;

endmodule

// File: tb/tb_bp_fpga_host_io_arbiter.sv
// Directed bench for bp_fpga_host_io_arbiter with an issuer-ID scoreboard queue.
module tb_bp_fpga_host_io_arbiter;

   localparam int N  = 2;
   localparam int W  = 32;
   localparam int D  = 4;
   localparam int CW = $clog2(D+1);

   logic            clk_i = 1'b0;
   logic            reset_n_i;
   logic [N*W-1:0]  req_cmd_i;
   logic [N-1:0]    req_cmd_v_i;
   logic [N-1:0]    req_cmd_ready_and_o;
   logic [W-1:0]    req_resp_o;
   logic [N-1:0]    req_resp_v_o;
   logic [N-1:0]    req_resp_yumi_i;
   logic [W-1:0]    host_cmd_o;
   logic            host_cmd_v_o;
   logic            host_cmd_ready_and_i;
   logic [W-1:0]    host_resp_i;
   logic            host_resp_v_i;
   logic            host_resp_yumi_o;
   logic [CW-1:0]   outstanding_o;
   logic            error_o;

   int          n_chk  = 0;
   int          n_fail = 0;
   int          exp_q[$];
   int          m_rr;
   bit          m_lock;
   int          m_g;
   bit          m_err;
   logic [W-1:0] seqn [N];

   bp_fpga_host_io_arbiter #(
      .num_req_p(N), .msg_width_p(W), .max_outstanding_p(D)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .req_cmd_i(req_cmd_i), .req_cmd_v_i(req_cmd_v_i), .req_cmd_ready_and_o(req_cmd_ready_and_o),
      .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o), .req_resp_yumi_i(req_resp_yumi_i),
      .host_cmd_o(host_cmd_o), .host_cmd_v_o(host_cmd_v_o), .host_cmd_ready_and_i(host_cmd_ready_and_i),
      .host_resp_i(host_resp_i), .host_resp_v_i(host_resp_v_i), .host_resp_yumi_o(host_resp_yumi_o),
      .outstanding_o(outstanding_o), .error_o(error_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [W-1:0] req_data(input int k);
      return 32'hB000_0000 | (32'(k) << 16) | seqn[k];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, predict, compare combinational outputs, clock, update model, compare state.
   task automatic cyc(input logic [1:0] v, input logic cr, input logic rv, input logic [1:0] ry);
      bit         cv;
      int         g;
      logic [1:0] e_rdy;
      logic [1:0] e_rv;
      bit         e_yumi;
      bit         hs;
      bit         pp;
      req_cmd_v_i          = v;
      host_cmd_ready_and_i = cr;
      host_resp_v_i        = rv;
      req_resp_yumi_i      = ry;
      host_resp_i          = $urandom;
      req_cmd_i            = {req_data(1), req_data(0)};
      #2;
      cv = 1'b0;
      g  = 0;
      if (m_lock) begin
         cv = 1'b1;
         g  = m_g;
      end else if (exp_q.size() < D) begin
         for (int i = 0; i < N; i++) begin
            int idx;
            idx = (m_rr + i) % N;
            if (!cv && v[idx]) begin
               cv = 1'b1;
               g  = idx;
            end
         end
      end
      hs    = cv & cr;
      e_rdy = hs ? 2'(1 << g) : 2'b00;
      if (exp_q.size() > 0) begin
         e_rv   = rv ? 2'(1 << exp_q[0]) : 2'b00;
         e_yumi = rv & ry[exp_q[0]];
      end else begin
         e_rv   = 2'b00;
         e_yumi = rv;
      end
      pp = e_yumi && (exp_q.size() > 0);
      chk("host_cmd_v", 64'(host_cmd_v_o), 64'(cv));
      if (cv) chk("host_cmd", 64'(host_cmd_o), 64'(req_data(g)));
      chk("cmd_ready", 64'(req_cmd_ready_and_o), 64'(e_rdy));
      chk("resp_v", 64'(req_resp_v_o), 64'(e_rv));
      chk("resp_yumi", 64'(host_resp_yumi_o), 64'(e_yumi));
      if (rv) chk("resp_data", 64'(req_resp_o), 64'(host_resp_i));
      @(posedge clk_i);
      #1;
      if (rv && exp_q.size() == 0) m_err = 1'b1;
      if (pp) void'(exp_q.pop_front());
      if (hs) begin
         exp_q.push_back(g);
         m_rr   = (g + 1) % N;
         m_lock = 1'b0;
         seqn[g] = seqn[g] + 1;
      end else if (cv) begin
         m_lock = 1'b1;
         m_g    = g;
      end
      chk("outstanding", 64'(outstanding_o), 64'(exp_q.size()));
      chk("error", 64'(error_o), 64'(m_err));
   endtask

   initial begin
      seqn[0] = '0;
      seqn[1] = '0;
      m_rr = 0; m_lock = 1'b0; m_g = 0; m_err = 1'b0;
      // reset with active inputs: outputs must be forced low
      reset_n_i            = 1'b0;
      req_cmd_v_i          = 2'b11;
      host_cmd_ready_and_i = 1'b1;
      host_resp_v_i        = 1'b1;
      req_resp_yumi_i      = 2'b11;
      host_resp_i          = '0;
      req_cmd_i            = {req_data(1), req_data(0)};
      #2;
      chk("rst_host_cmd_v", 64'(host_cmd_v_o), 64'(0));
      chk("rst_cmd_ready", 64'(req_cmd_ready_and_o), 64'(0));
      chk("rst_resp_v", 64'(req_resp_v_o), 64'(0));
      chk("rst_resp_yumi", 64'(host_resp_yumi_o), 64'(0));
      chk("rst_outstanding", 64'(outstanding_o), 64'(0));
      chk("rst_error", 64'(error_o), 64'(0));
      req_cmd_v_i = '0; host_cmd_ready_and_i = 1'b0; host_resp_v_i = 1'b0; req_resp_yumi_i = '0;
      @(negedge clk_i);
      reset_n_i = 1'b1;
      @(posedge clk_i);
      #1;

      // single command and response from req0
      cyc(2'b01, 1'b1, 1'b0, 2'b00);
      cyc(2'b00, 1'b0, 1'b1, 2'b01);

      // both requesters streaming with immediate responses
      for (int i = 0; i < 6; i++) cyc(2'b11, 1'b1, exp_q.size() > 0, 2'b11);
      cyc(2'b00, 1'b0, 1'b1, 2'b11);

      // host stall locks req0 even after req1 asserts
      cyc(2'b01, 1'b0, 1'b0, 2'b00);
      cyc(2'b01, 1'b0, 1'b0, 2'b00);
      cyc(2'b11, 1'b0, 1'b0, 2'b00);
      cyc(2'b11, 1'b1, 1'b0, 2'b00);
      cyc(2'b11, 1'b1, 1'b0, 2'b00);
      cyc(2'b00, 1'b0, 1'b1, 2'b01);
      cyc(2'b00, 1'b0, 1'b1, 2'b01);   // non-owner yumi ignored
      cyc(2'b00, 1'b0, 1'b1, 2'b10);

      // fill the ID FIFO, check full blocking and accept-after-pop
      for (int i = 0; i < 4; i++) cyc(2'b11, 1'b1, 1'b0, 2'b00);
      cyc(2'b11, 1'b1, 1'b0, 2'b00);
      cyc(2'b11, 1'b1, 1'b1, 2'b11);
      cyc(2'b11, 1'b1, 1'b0, 2'b00);
      for (int i = 0; i < 4; i++) cyc(2'b00, 1'b0, 1'b1, 2'b11);

      // orphan response: drained, sticky error
      cyc(2'b00, 1'b0, 1'b1, 2'b00);
      cyc(2'b00, 1'b0, 1'b0, 2'b00);
      cyc(2'b01, 1'b1, 1'b0, 2'b00);

      // async reset while locked with outstanding IDs
      cyc(2'b11, 1'b1, 1'b0, 2'b00);
      cyc(2'b11, 1'b0, 1'b0, 2'b00);
      req_cmd_v_i = 2'b11; host_cmd_ready_and_i = 1'b0; host_resp_v_i = 1'b1; req_resp_yumi_i = 2'b11;
      #2;
      reset_n_i = 1'b0;
      #1;
      chk("arst_host_cmd_v", 64'(host_cmd_v_o), 64'(0));
      chk("arst_cmd_ready", 64'(req_cmd_ready_and_o), 64'(0));
      chk("arst_resp_v", 64'(req_resp_v_o), 64'(0));
      chk("arst_resp_yumi", 64'(host_resp_yumi_o), 64'(0));
      chk("arst_outstanding", 64'(outstanding_o), 64'(0));
      chk("arst_error", 64'(error_o), 64'(0));
      exp_q.delete();
      m_rr = 0; m_lock = 1'b0; m_g = 0; m_err = 1'b0;
      req_cmd_v_i = '0; host_cmd_ready_and_i = 1'b0; host_resp_v_i = 1'b0; req_resp_yumi_i = '0;
      @(negedge clk_i);
      reset_n_i = 1'b1;
      @(posedge clk_i);
      #1;
      cyc(2'b11, 1'b1, 1'b0, 2'b00);
      cyc(2'b00, 1'b0, 1'b1, 2'b11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
